// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and types for the UART-to-SD command frame controller.
// Holds the FSM encoding, the CRC7 polynomial and the frame format constants.
package uart_cmd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [6:0]  CRC7_POLY     = 7'h09;
   localparam int unsigned FRAME_LEN     = 6;
   localparam logic [1:0]  START_PATTERN = 2'b01;

endpackage

// File: rtl/uart_cmd_ctrl_crc7.sv
// Combinational bytewise CRC7 (x^7 + x^3 + 1): next CRC from current CRC and one byte.
// Bits are consumed MSB first, matching SD command framing.
module crc7_byte
   import uart_cmd_ctrl_pkg::*;
(
   input  logic [6:0] crc_in,
   input  logic [7:0] data_in,
   output logic [6:0] crc_out
);

   logic [6:0] crc_work;
   logic       feedback;

   always_comb begin
      crc_work = crc_in;
      feedback = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         feedback = crc_work[6] ^ data_in[i];
         crc_work = {crc_work[5:0], 1'b0};
         if (feedback) begin
            crc_work = crc_work ^ CRC7_POLY;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 6-byte SD command frames from a UART byte stream, checks CRC7 and end bit,
// and holds the decoded command until the downstream consumer accepts it.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ack,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        crc_err,
   output logic        frame_err,
   output logic        overrun
);

   localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     LAST_CNT = 3'(FRAME_LEN - 1);

   state_t        state_q, state_d;
   logic [2:0]    count_q, count_d;
   logic [6:0]    crc_q, crc_d, crc_next;
   logic [CW-1:0] idle_q, idle_d;
   logic [7:0]    trailer_q, trailer_d;
   logic [5:0]    index_q, index_d;
   logic [31:0]   arg_q, arg_d;
   logic          valid_q, valid_d;
   logic          ack_q, ack_d;
   logic          crc_err_q, crc_err_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          crc_err_set, frame_err_set, overrun_set;

   crc7_byte u_crc7 (
      .crc_in  (crc_q),
      .data_in (rx_data),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      crc_d         = crc_q;
      idle_d        = idle_q;
      trailer_d     = trailer_q;
      index_d       = index_q;
      arg_d         = arg_q;
      valid_d       = valid_q;
      ack_d         = rx_valid;
      crc_err_set   = 1'b0;
      frame_err_set = 1'b0;
      overrun_set   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (rx_valid) begin
               if (rx_data[7:6] == START_PATTERN) begin
                  index_d = rx_data[5:0];
                  crc_d   = crc_next;
                  count_d = 3'd1;
                  state_d = ST_RECV;
               end else begin
                  frame_err_set = 1'b1;
               end
            end
         end
         ST_RECV: begin
            // An arriving byte always beats a timeout expiring in the same cycle.
            if (rx_valid) begin
               idle_d = '0;
               if (count_q == LAST_CNT) begin
                  trailer_d = rx_data;
                  state_d   = ST_CHECK;
               end else begin
                  arg_d   = {arg_q[23:0], rx_data};
                  crc_d   = crc_next;
                  count_d = count_q + 3'd1;
               end
            end else if (idle_q == IDLE_MAX) begin
               frame_err_set = 1'b1;
               state_d       = ST_IDLE;
               count_d       = '0;
               crc_d         = '0;
               idle_d        = '0;
            end else begin
               idle_d = idle_q + CW'(1);
            end
         end
         ST_CHECK: begin
            overrun_set = rx_valid;
            if (trailer_q[7:1] == crc_q && trailer_q[0]) begin
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               crc_err_set   = (trailer_q[7:1] != crc_q);
               frame_err_set = (trailer_q[7:1] == crc_q);
               state_d       = ST_IDLE;
               count_d       = '0;
               crc_d         = '0;
            end
         end
         ST_HOLD: begin
            overrun_set = rx_valid;
            if (valid_q && cmd_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               count_d = '0;
               crc_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            crc_d   = '0;
            valid_d = 1'b0;
         end
      endcase

      crc_err_d   = crc_err_set;
      frame_err_d = frame_err_set & ~crc_err_set;
      overrun_d   = overrun_set & ~crc_err_set & ~frame_err_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         crc_q       <= '0;
         idle_q      <= '0;
         trailer_q   <= '0;
         index_q     <= '0;
         arg_q       <= '0;
         valid_q     <= 1'b0;
         ack_q       <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         crc_q       <= crc_d;
         idle_q      <= idle_d;
         trailer_q   <= trailer_d;
         index_q     <= index_d;
         arg_q       <= arg_d;
         valid_q     <= valid_d;
         ack_q       <= ack_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_ack    = ack_q;
   assign cmd_index = index_q;
   assign cmd_arg   = arg_q;
   assign cmd_valid = valid_q;
   assign crc_err   = crc_err_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max idle clk cycles allowed between bytes of one frame.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_data, input, 8, received byte from UART receiver.
REQ-005 SHALL have port rx_valid, input, 1, receiver "contains data" strobe; byte valid this cycle.
REQ-006 SHALL have port rx_ack, output, 1, one-cycle acknowledge to receiver (its ctrl_out_rx_contains_data).
REQ-007 SHALL have port cmd_index, output, 6, assembled SD command index.
REQ-008 SHALL have port cmd_arg, output, 32, assembled SD command argument.
REQ-009 SHALL have port cmd_valid, output, 1, command fields valid.
REQ-010 SHALL have port cmd_ready, input, 1, downstream accepts command.
REQ-011 SHALL have ports crc_err, frame_err, overrun, outputs, 1 each, single-cycle error pulses.

Function
REQ-012 SHALL assemble 6-byte SD command frames, MSB-first: byte0 = {2'b01, index[5:0]}, bytes1-4 = arg[31:0], byte5 = {crc7[6:0], 1'b1}.
REQ-013 SHALL implement FSM states IDLE, RECV, CHECK, HOLD.
REQ-014 IDLE: on rx_valid with rx_data[7:6]==2'b01, latch index, seed CRC, byte count=1, go RECV; otherwise pulse frame_err, stay IDLE.
REQ-015 RECV: on each rx_valid, shift byte into arg (bytes 1-4) or latch as trailer (byte 5); after byte 5 go CHECK.
REQ-016 SHALL compute CRC7 (poly x^7+x^3+1, init 0) over bytes 0-4, serially or bytewise, complete by CHECK.
REQ-017 CHECK (exactly one cycle): trailer[7:1]==CRC and trailer[0]==1 -> HOLD with cmd_valid=1; CRC mismatch -> crc_err pulse, IDLE; bad end bit with good CRC -> frame_err pulse, IDLE.
REQ-018 Latency: cmd_valid SHALL rise two cycles after the cycle byte 5 is presented.
REQ-019 HOLD: cmd_valid, cmd_index, cmd_arg held stable until cmd_valid&&cmd_ready; then IDLE next cycle.
REQ-020 rx_ack SHALL pulse the cycle after every rx_valid, in all states (receiver always drained).
REQ-021 rx_valid during CHECK or HOLD: byte dropped, overrun pulsed, state unchanged.
REQ-022 RECV idle counter: cleared on each rx_valid; on reaching TIMEOUT_CYCLES-1 with no rx_valid -> frame_err pulse, IDLE, partial frame discarded.
REQ-023 rx_valid in the same cycle as timeout expiry: byte SHALL win, no timeout.
REQ-024 Error pulses SHALL be exactly one cycle; at most one error type per cycle, priority crc_err > frame_err > overrun.
REQ-025 Byte counter SHALL be 3 bits and never wrap past 5; counter cleared on every return to IDLE.

Reset
REQ-026 On reset: state IDLE, byte count 0, CRC 0, idle counter 0, cmd_index 0, cmd_arg 0, cmd_valid 0, rx_ack 0, all error pulses 0.
REQ-027 Reset mid-frame or in HOLD SHALL discard the frame; no cmd_valid or error pulse follows deassertion.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, CRC7 polynomial constant 7'h09, frame length constant 6, start-pattern constant 2'b01.
REQ-029 CRC7 SHALL be a sub-module crc7_byte (combinational next-CRC from current CRC and byte); all else in one module.

Verification
REQ-030 Send 40 00 00 00 00 95 -> cmd_valid, cmd_index=0, cmd_arg=32'h0, no errors.
REQ-031 Send 48 00 00 01 AA 87, cmd_ready low 10 cycles -> cmd_index=8, cmd_arg=32'h000001AA held stable, released one cycle after ready.
REQ-032 Send 40 00 00 00 00 97 -> crc_err single pulse, no cmd_valid, IDLE.
REQ-033 Send header FF -> frame_err pulse; send 3 bytes then stall TIMEOUT_CYCLES -> frame_err, next valid frame accepted normally.
REQ-034 During HOLD send byte 55 -> overrun pulse, rx_ack pulse, command fields unchanged.
REQ-035 Assert reset after byte 3 of a frame -> all outputs 0; following 40 00 00 00 00 95 decodes correctly.
